// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage
package fetch_pkg;
    localparam int FETCH_DEPTH = 2;
    localparam int WORD_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO of {pc, instr}; flush overrides push/pop
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic [1:0]   count,
    output fetch_entry_t head
);
    fetch_entry_t mem [FETCH_DEPTH];
    logic rd_ptr, wr_ptr;
    assign head = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, one-deep inflight slot, credit-based issue and redirect flush
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);
    logic [31:0]  pc_q, inflight_pc_q;
    logic         inflight_q, pop, push, issue;
    logic [1:0]   count;
    fetch_entry_t head;
    assign mem_addr  = pc_q;
    assign out_valid = count != 2'd0;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q & ~redirect_valid;
    // pop implies count >= 1, so the credit sum cannot underflow
    assign issue = ~redirect_valid & (({1'b0, count} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q       <= {redirect_pc[31:2], 2'b00};
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + 32'(WORD_BYTES);
            end
        end
    end
    fetch_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_entry('{pc: inflight_pc_q, instr: mem_rdata}),
        .count     (count),
        .head      (head)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch timing, stall, redirect, random backpressure and reset
module tb_fetch_unit;
    import fetch_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [31:0] addr0, rdata0, rpc0, instr0, pc0;
    logic [31:0] addr1, rdata1, rpc1, instr1, pc1;
    logic        rv0, ready0, valid0, rv1, ready1, valid1;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_pc;
    fetch_unit u0 (
        .clk(clk), .rst_n(rst_n), .mem_addr(addr0), .mem_rdata(rdata0),
        .redirect_valid(rv0), .redirect_pc(rpc0), .out_valid(valid0),
        .out_ready(ready0), .out_instr(instr0), .out_pc(pc0)
    );
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .rst_n(rst_n), .mem_addr(addr1), .mem_rdata(rdata1),
        .redirect_valid(rv1), .redirect_pc(rpc1), .out_valid(valid1),
        .out_ready(ready1), .out_instr(instr1), .out_pc(pc1)
    );
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA000_0000 + {22'b0, a[11:2]};
    endfunction
    // memory model: 1024 words, mem[i] = A000_0000 + i, one-cycle read latency
    always @(posedge clk) begin
        rdata0 <= word(addr0);
        rdata1 <= word(addr1);
    end
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if (u0.count > 2'd2) begin
                miscompares++;
                $display("FAIL fifo_count_bound: got %0d required <= 2", u0.count);
            end
        end
    end

    task automatic test_reset();
        rv0 = 1'b0; rpc0 = '0; rv1 = 1'b0; rpc1 = '0;
        ready0 = 1'b0; ready1 = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({valid0, pc0, instr0, addr0} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b pc=%h instr=%h addr=%h required 0/0/0/0", valid0, pc0, instr0, addr0);
        end
        vectors++;
        if ({valid1, addr1} !== {1'b0, 32'hFFFF_FFF8}) begin
            miscompares++;
            $display("FAIL reset_pc_param: got v=%b addr=%h required 0/fffffff8", valid1, addr1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stall_and_wrap();
        logic [31:0] e1;
        @(negedge clk);
        vectors++;
        if ({valid0, valid1} !== 2'b00) begin
            miscompares++;
            $display("FAIL first_cycle_valid: got %b%b required 00", valid0, valid1);
        end
        @(negedge clk);
        vectors++;
        if ({valid0, pc0, instr0} !== {1'b1, 32'h0, 32'hA000_0000}) begin
            miscompares++;
            $display("FAIL first_valid_u0: got v=%b pc=%h instr=%h required 1/0/a0000000", valid0, pc0, instr0);
        end
        vectors++;
        if ({valid1, pc1, instr1} !== {1'b1, 32'hFFFF_FFF8, word(32'hFFFF_FFF8)}) begin
            miscompares++;
            $display("FAIL first_valid_u1: got v=%b pc=%h instr=%h required 1/fffffff8", valid1, pc1, instr1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({valid0, pc0, addr0, u0.count} !== {1'b1, 32'h0, 32'h8, 2'd2}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h addr=%h cnt=%0d required 1/0/8/2", i, valid0, pc0, addr0, u0.count);
            end
            e1 = 32'hFFFF_FFFC + 32'(4 * i);
            vectors++;
            if ({valid1, pc1, instr1} !== {1'b1, e1, word(e1)}) begin
                miscompares++;
                $display("FAIL wrap_seq[%0d]: got v=%b pc=%h instr=%h required pc=%h", i, valid1, pc1, instr1, e1);
            end
        end
        ready0 = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({valid0, pc0, instr0} !== {1'b1, exp_pc, word(exp_pc)}) begin
                miscompares++;
                $display("FAIL stall_release[%0d]: got v=%b pc=%h instr=%h required pc=%h", i, valid0, pc0, instr0, exp_pc);
            end
            exp_pc += 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({valid0, pc0, instr0} !== {1'b1, exp_pc, word(exp_pc)}) begin
                miscompares++;
                $display("FAIL stream[%0d]: got v=%b pc=%h instr=%h required pc=%h", i, valid0, pc0, instr0, exp_pc);
            end
            exp_pc += 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_pop();
        rv0 = 1'b1; rpc0 = 32'h0000_0103;
        @(negedge clk);
        rv0 = 1'b0;
        vectors++;
        if ({valid0, u0.count, addr0} !== {1'b0, 2'd0, 32'h100}) begin
            miscompares++;
            $display("FAIL redirect_r1: got v=%b cnt=%0d addr=%h required 0/0/100", valid0, u0.count, addr0);
        end
        @(negedge clk);
        vectors++;
        if (valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_r2: got v=%b required 0", valid0);
        end
        exp_pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({valid0, pc0, instr0} !== {1'b1, exp_pc, word(exp_pc)}) begin
                miscompares++;
                $display("FAIL redirect_target[%0d]: got v=%b pc=%h instr=%h required pc=%h", i, valid0, pc0, instr0, exp_pc);
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_back_to_back();
        ready0 = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({valid0, pc0, u0.count} !== {1'b1, 32'h108, 2'd2}) begin
            miscompares++;
            $display("FAIL b2b_full: got v=%b pc=%h cnt=%0d required 1/108/2", valid0, pc0, u0.count);
        end
        rv0 = 1'b1; rpc0 = 32'h0000_0300;
        @(negedge clk);
        rpc0 = 32'h0000_0404;
        vectors++;
        if ({valid0, addr0} !== {1'b0, 32'h300}) begin
            miscompares++;
            $display("FAIL b2b_first: got v=%b addr=%h required 0/300", valid0, addr0);
        end
        @(negedge clk);
        rv0 = 1'b0;
        vectors++;
        if ({valid0, addr0} !== {1'b0, 32'h404}) begin
            miscompares++;
            $display("FAIL b2b_second: got v=%b addr=%h required 0/404", valid0, addr0);
        end
        @(negedge clk);
        vectors++;
        if (valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: got v=%b required 0", valid0);
        end
        @(negedge clk);
        vectors++;
        if ({valid0, pc0, instr0} !== {1'b1, 32'h404, word(32'h404)}) begin
            miscompares++;
            $display("FAIL b2b_target: got v=%b pc=%h instr=%h required pc=404", valid0, pc0, instr0);
        end
        ready0 = 1'b1;
        @(negedge clk);
        vectors++;
        if ({valid0, pc0} !== {1'b1, 32'h408}) begin
            miscompares++;
            $display("FAIL b2b_next: got v=%b pc=%h required 1/408", valid0, pc0);
        end
        exp_pc = 32'h408;
    endtask

    task automatic test_random_ready();
        logic [31:0] start;
        start = exp_pc;
        for (int i = 0; i < 200; i++) begin
            ready0 = 1'($urandom_range(0, 1));
            if (valid0) begin
                vectors++;
                if ({pc0, instr0} !== {exp_pc, word(exp_pc)}) begin
                    miscompares++;
                    $display("FAIL random_seq[%0d]: got pc=%h instr=%h required pc=%h", i, pc0, instr0, exp_pc);
                end
                if (ready0)
                    exp_pc += 32'd4;
            end
            @(negedge clk);
        end
        vectors++;
        if (exp_pc - start < 32'd160) begin
            miscompares++;
            $display("FAIL random_progress: got %0d instrs required >= 40", (exp_pc - start) / 4);
        end
    endtask

    task automatic test_midreset();
        ready0 = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({valid0, pc0, addr0, valid1} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_clear: got v=%b pc=%h addr=%h v1=%b required 0/0/0/0", valid0, pc0, addr0, valid1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({valid0, valid1} !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset_gap: got %b%b required 00", valid0, valid1);
        end
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({valid0, pc0, instr0} !== {1'b1, exp_pc, word(exp_pc)}) begin
                miscompares++;
                $display("FAIL midreset_restart[%0d]: got v=%b pc=%h instr=%h required pc=%h", i, valid0, pc0, instr0, exp_pc);
            end
            exp_pc += 32'd4;
        end
    endtask

    initial begin
        test_reset();
        test_stall_and_wrap();
        test_stream();
        test_redirect_pop();
        test_back_to_back();
        test_random_ready();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
